// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped write-through data cache.
package cache_pkg;

  localparam int INDEXWIDTH = 6;
  localparam int TAGWIDTH   = 32 - INDEXWIDTH - 2;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REFILL,
    WRMEM,
    RESP
  } state_e;

  typedef struct packed {
    logic [TAGWIDTH-1:0]   tag;
    logic [INDEXWIDTH-1:0] index;
    logic [1:0]            offset;
  } addr_split_t;

  function automatic addr_split_t split_addr(input logic [31:0] addr);
    return addr_split_t'(addr);
  endfunction

endpackage

// File: rtl/cache_perf_cnt.sv
// Hit/miss event counters, 16 bits each, wrapping silently on overflow.
module cache_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit_inc_i,
  input  logic        miss_inc_i,
  output logic [15:0] hit_cnt_o,
  output logic [15:0] miss_cnt_o
);

  logic [1:0]  inc;
  logic [15:0] cnt_q [2];

  assign inc = {miss_inc_i, hit_inc_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q[gi] <= '0;
      end else if (inc[gi]) begin
        cnt_q[gi] <= cnt_q[gi] + 16'd1;
      end
    end
  end

  assign hit_cnt_o  = cnt_q[0];
  assign miss_cnt_o = cnt_q[1];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate cache controller.
// The valid/tag/data arrays live outside; this block sequences them and the memory port.
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int INDEXWIDTH = cache_pkg::INDEXWIDTH,
  parameter int TAGWIDTH   = cache_pkg::TAGWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic                  core_write,
  input  logic [31:0]           core_addr,
  input  logic [31:0]           core_wdata,
  output logic [31:0]           core_rdata,
  output logic                  core_done,
  input  logic                  valid_in,
  output logic                  valid_web,
  output logic                  valid_cs,
  output logic                  valid_oe,
  output logic [INDEXWIDTH-1:0] addr_index,
  input  logic [TAGWIDTH-1:0]   tag_in,
  output logic [TAGWIDTH-1:0]   tag_out,
  output logic                  tag_we,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  data_we,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt
);

  state_e      state_q, state_d;
  logic [29:0] addr_q;  // word address; byte offset is always zero
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        hit, hit_inc, miss_inc;
  logic [1:0]  unused_offset;

  assign unused_offset = core_addr[1:0];
  assign hit           = valid_in & (tag_in == addr_q[29:INDEXWIDTH]);
  assign addr_index    = (state_q == IDLE) ? core_addr[INDEXWIDTH+1:2] : addr_q[INDEXWIDTH-1:0];
  assign core_rdata    = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (state_q == IDLE && core_req) begin
        addr_q  <= core_addr[31:2];
        write_q <= core_write;
        wdata_q <= core_wdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    valid_oe  = 1'b0;
    valid_cs  = 1'b0;
    valid_web = 1'b0;
    tag_we    = 1'b0;
    tag_out   = '0;
    data_we   = 1'b0;
    data_out  = '0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    core_done = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_req) state_d = CHECK;
      end
      CHECK: begin
        valid_oe = 1'b1;
        hit_inc  = hit;
        miss_inc = ~hit;
        if (write_q) begin
          // Update the line only if already present; the store always goes to memory.
          data_we  = hit;
          data_out = hit ? wdata_q : '0;
          state_d  = WRMEM;
        end else if (hit) begin
          rdata_d = data_in;
          state_d = RESP;
        end else begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q, 2'b00};
        if (mem_ack) begin
          valid_cs  = 1'b1;
          valid_web = 1'b1;
          tag_we    = 1'b1;
          tag_out   = addr_q[29:INDEXWIDTH];
          data_we   = 1'b1;
          data_out  = mem_rdata;
          rdata_d   = mem_rdata;
          state_d   = RESP;
        end
      end
      WRMEM: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {addr_q, 2'b00};
        mem_wdata = wdata_q;
        if (mem_ack) state_d = RESP;
      end
      RESP: begin
        core_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  cache_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst        (rst),
    .hit_inc_i  (hit_inc),
    .miss_inc_i (miss_inc),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
  );

endmodule
